triangle_scheduler: RTL and testbench

TRIANGLE_SCHEDULER -- requirements
Module: triangle_scheduler

---
 rtl/gpu_pkg.sv | 18 +
 rtl/triangle_scheduler_if.sv | 25 ++
 rtl/sched_watchdog.sv | 31 +++
 rtl/triangle_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_triangle_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the triangle scheduler.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    VERTEX = 3'd2,
    PIXEL  = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  localparam int VERTICES_PER_TRI = 3;

  function automatic logic is_stage(input sched_state_t s);
    return (s == FETCH) || (s == VERTEX) || (s == PIXEL);
  endfunction

endpackage

// File: rtl/triangle_scheduler_if.sv
// Start/done handshakes and current triangle addresses towards the render stages.
interface triangle_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  fetch_start;
  logic                  fetch_eoc;
  logic                  ver_start;
  logic                  ver_eoc;
  logic                  pix_start;
  logic                  pix_eoc;
  logic [ADDR_WIDTH-1:0] curr_addr_vertex;
  logic [ADDR_WIDTH-1:0] curr_addr_color;

  modport master (
    output fetch_start, ver_start, pix_start, curr_addr_vertex, curr_addr_color,
    input  fetch_eoc, ver_eoc, pix_eoc
  );

  modport slave (
    input  fetch_start, ver_start, pix_start, curr_addr_vertex, curr_addr_color,
    output fetch_eoc, ver_eoc, pix_eoc
  );

endinterface

// File: rtl/sched_watchdog.sv
// Per-stage watchdog: counts cycles spent in a stage, restarted by each start pulse.
module sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // The start cycle itself is the first counted cycle, so a clear loads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CNT_W'(1);
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The count left over from a previous stage is masked during the start cycle.
  assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/triangle_scheduler.sv
// Walks a frame triangle by triangle through fetch, vertex and pixel stages.
module triangle_scheduler
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int VERTEX_SIZE    = 6,
  parameter int COLOR_BYTES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [31:0]            triangles_count,
  input  logic [ADDR_WIDTH-1:0]  base_addr_vertex,
  input  logic [ADDR_WIDTH-1:0]  base_addr_color,
  triangle_scheduler_if.master   stg,
  output logic                   frame_end,
  output logic                   busy,
  output logic [31:0]            tri_index,
  output logic                   timeout_err
);

  localparam logic [ADDR_WIDTH-1:0] VTX_STRIDE = ADDR_WIDTH'(VERTICES_PER_TRI * VERTEX_SIZE);
  localparam logic [ADDR_WIDTH-1:0] COL_STRIDE = ADDR_WIDTH'(COLOR_BYTES);

  // Assert follows reset immediately; release is delayed two clk edges.
  logic rst_meta;
  logic rst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta <= 1'b1;
      rst      <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst      <= rst_meta;
    end
  end

  sched_state_t          state_q, state_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           tri_q, tri_d;
  logic [ADDR_WIDTH-1:0] addr_v_q, addr_v_d;
  logic [ADDR_WIDTH-1:0] addr_c_q, addr_c_d;
  logic                  fetch_start_q, fetch_start_d;
  logic                  ver_start_q, ver_start_d;
  logic                  pix_start_q, pix_start_d;
  logic                  frame_end_q, frame_end_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  wd_expired;
  logic                  fetch_ok, ver_ok, pix_ok, last_tri;

  sched_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (fetch_start_q | ver_start_q | pix_start_q),
    .enable  (is_stage(state_q)),
    .expired (wd_expired)
  );

  // An eoc counts only in its own state and never in that state's start cycle.
  assign fetch_ok = (state_q == FETCH)  && stg.fetch_eoc && !fetch_start_q;
  assign ver_ok   = (state_q == VERTEX) && stg.ver_eoc   && !ver_start_q;
  assign pix_ok   = (state_q == PIXEL)  && stg.pix_eoc   && !pix_start_q;
  assign last_tri = (tri_q == (count_q - 32'd1));

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tri_d         = tri_q;
    addr_v_d      = addr_v_q;
    addr_c_d      = addr_c_q;
    err_d         = err_q;
    fetch_start_d = 1'b0;
    ver_start_d   = 1'b0;
    pix_start_d   = 1'b0;
    frame_end_d   = 1'b0;
    busy_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          count_d  = triangles_count;
          addr_v_d = base_addr_vertex;
          addr_c_d = base_addr_color;
          tri_d    = 32'd0;
          err_d    = 1'b0;
          if (triangles_count == 32'd0) begin
            state_d = DONE;
          end else begin
            state_d       = FETCH;
            fetch_start_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (fetch_ok) begin
          state_d     = VERTEX;
          ver_start_d = 1'b1;
        end else if (wd_expired) begin
          err_d       = 1'b1;
          state_d     = DONE;
          frame_end_d = 1'b1;
        end
      end
      VERTEX: begin
        if (ver_ok) begin
          state_d     = PIXEL;
          pix_start_d = 1'b1;
        end else if (wd_expired) begin
          err_d       = 1'b1;
          state_d     = DONE;
          frame_end_d = 1'b1;
        end
      end
      PIXEL: begin
        if (pix_ok) begin
          if (last_tri) begin
            state_d     = DONE;
            frame_end_d = 1'b1;
          end else begin
            state_d       = FETCH;
            fetch_start_d = 1'b1;
            tri_d         = tri_q + 32'd1;
            addr_v_d      = addr_v_q + VTX_STRIDE;
            addr_c_d      = addr_c_q + COL_STRIDE;
          end
        end else if (wd_expired) begin
          err_d       = 1'b1;
          state_d     = DONE;
          frame_end_d = 1'b1;
        end
      end
      DONE: begin
        // An empty frame enters DONE without the pulse and raises it one cycle later.
        if (frame_end_q) begin
          state_d = IDLE;
        end else begin
          frame_end_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= 32'd0;
      tri_q         <= 32'd0;
      addr_v_q      <= '0;
      addr_c_q      <= '0;
      fetch_start_q <= 1'b0;
      ver_start_q   <= 1'b0;
      pix_start_q   <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tri_q         <= tri_d;
      addr_v_q      <= addr_v_d;
      addr_c_q      <= addr_c_d;
      fetch_start_q <= fetch_start_d;
      ver_start_q   <= ver_start_d;
      pix_start_q   <= pix_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign stg.fetch_start      = fetch_start_q;
  assign stg.ver_start        = ver_start_q;
  assign stg.pix_start        = pix_start_q;
  assign stg.curr_addr_vertex = addr_v_q;
  assign stg.curr_addr_color  = addr_c_q;
  assign frame_end            = frame_end_q;
  assign busy                 = busy_q;
  assign tri_index            = tri_q;
  assign timeout_err          = err_q;

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed bench for triangle_scheduler; inputs driven and outputs sampled on the falling edge.
module tb_triangle_scheduler;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [31:0] triangles_count;
  logic [31:0] base_addr_vertex;
  logic [31:0] base_addr_color;
  logic        frame_end;
  logic        busy;
  logic [31:0] tri_index;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fs = 0, n_vs = 0, n_ps = 0, n_fe = 0;

  triangle_scheduler_if #(.ADDR_WIDTH(32)) sif ();

  triangle_scheduler #(
    .ADDR_WIDTH     (32),
    .VERTEX_SIZE    (6),
    .COLOR_BYTES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .triangles_count  (triangles_count),
    .base_addr_vertex (base_addr_vertex),
    .base_addr_color  (base_addr_color),
    .stg              (sif.master),
    .frame_end        (frame_end),
    .busy             (busy),
    .tri_index        (tri_index),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sif.fetch_start) n_fs++;
    if (sif.ver_start)   n_vs++;
    if (sif.pix_start)   n_ps++;
    if (frame_end)       n_fe++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_eoc(input int stage, input logic v);
    case (stage)
      0: sif.fetch_eoc = v;
      1: sif.ver_eoc   = v;
      default: sif.pix_eoc = v;
    endcase
  endtask

  // From a start cycle, raise that stage's eoc dly cycles later for one cycle.
  task automatic eoc_after(input int stage, input int dly);
    repeat (dly) @(negedge clk);
    set_eoc(stage, 1'b1);
    @(negedge clk);
    set_eoc(stage, 1'b0);
  endtask

  task automatic start_frame(input logic [31:0] cnt, input logic [31:0] vb, input logic [31:0] cb);
    frame_start      = 1'b1;
    triangles_count  = cnt;
    base_addr_vertex = vb;
    base_addr_color  = cb;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int seen;
    int waited;
    int base_s;
    int base_fe;
    reset            = 1'b1;
    frame_start      = 1'b0;
    triangles_count  = '0;
    base_addr_vertex = '0;
    base_addr_color  = '0;
    sif.fetch_eoc    = 1'b0;
    sif.ver_eoc      = 1'b0;
    sif.pix_eoc      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_starts", {sif.fetch_start, sif.ver_start, sif.pix_start}, 0);
    check("rst_tri_index", tri_index, 0);
    check("rst_addrs", {sif.curr_addr_vertex, sif.curr_addr_color}, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Two triangles, eoc three cycles after each start
    base_s = n_fs;
    start_frame(32'd2, 32'h1000, 32'h2000);
    check("t1_fetch_start", sif.fetch_start, 1);
    check("t1_busy", busy, 1);
    check("t1_addr_v0", sif.curr_addr_vertex, 32'h1000);
    check("t1_addr_c0", sif.curr_addr_color, 32'h2000);
    check("t1_tri0", tri_index, 0);
    eoc_after(0, 3);
    check("t1_ver_start", sif.ver_start, 1);
    check("t1_fetch_low", sif.fetch_start, 0);
    eoc_after(1, 3);
    check("t1_pix_start", sif.pix_start, 1);
    eoc_after(2, 3);
    check("t1_fetch_start2", sif.fetch_start, 1);
    check("t1_tri1", tri_index, 1);
    check("t1_addr_v1", sif.curr_addr_vertex, 32'h1012);
    check("t1_addr_c1", sif.curr_addr_color, 32'h2002);
    eoc_after(0, 3);
    eoc_after(1, 3);
    eoc_after(2, 3);
    check("t1_frame_end", frame_end, 1);
    check("t1_busy_done", busy, 1);
    @(negedge clk);
    check("t1_frame_end_low", frame_end, 0);
    check("t1_busy_low", busy, 0);
    check("t1_fetch_pulses", n_fs - base_s, 2);

    // Empty frame
    base_s = n_fs + n_vs + n_ps;
    start_frame(32'd0, 32'h5555, 32'h6666);
    check("t2_busy1", busy, 1);
    check("t2_frame_end_early", frame_end, 0);
    @(negedge clk);
    check("t2_frame_end", frame_end, 1);
    check("t2_busy2", busy, 1);
    @(negedge clk);
    check("t2_busy_low", busy, 0);
    check("t2_no_starts", n_fs + n_vs + n_ps - base_s, 0);

    // Vertex stage never answers: watchdog ends the frame
    base_s = n_ps;
    start_frame(32'd1, 32'h3000, 32'h4000);
    eoc_after(0, 3);
    check("t3_ver_start", sif.ver_start, 1);
    seen = 0;
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_end) begin
        seen = 1;
        waited = i;
        break;
      end
    end
    check("t3_frame_end_seen", seen, 1);
    check("t3_timeout_latency", waited, 17);
    check("t3_timeout_err", timeout_err, 1);
    check("t3_no_pix_start", n_ps - base_s, 0);
    @(negedge clk);
    check("t3_busy_low", busy, 0);
    check("t3_err_sticky", timeout_err, 1);

    // Same-cycle eoc, stray eoc and a second frame_start are all ignored
    start_frame(32'd1, 32'h5000, 32'h6000);
    check("t4_err_cleared", timeout_err, 0);
    sif.fetch_eoc = 1'b1;
    @(negedge clk);
    sif.fetch_eoc = 1'b0;
    check("t4_same_cycle_eoc", sif.ver_start, 0);
    eoc_after(0, 2);
    check("t4_ver_start", sif.ver_start, 1);
    @(negedge clk);
    sif.fetch_eoc = 1'b1;
    @(negedge clk);
    sif.fetch_eoc = 1'b0;
    check("t4_stray_eoc", {sif.ver_start, sif.pix_start}, 0);
    eoc_after(1, 2);
    check("t4_pix_start", sif.pix_start, 1);
    @(negedge clk);
    start_frame(32'd5, 32'hAAAA0000, 32'hBBBB0000);
    check("t4_restart_addr", sif.curr_addr_vertex, 32'h5000);
    check("t4_restart_tri", tri_index, 0);
    check("t4_restart_fetch", sif.fetch_start, 0);
    eoc_after(2, 1);
    check("t4_frame_end", frame_end, 1);
    @(negedge clk);
    check("t4_busy_low", busy, 0);

    // Vertex and color addresses wrap
    start_frame(32'd2, 32'hFFFFFFF8, 32'hFFFFFFFF);
    eoc_after(0, 1);
    eoc_after(1, 1);
    eoc_after(2, 1);
    check("t5_wrap_v", sif.curr_addr_vertex, 32'h0000000A);
    check("t5_wrap_c", sif.curr_addr_color, 32'h00000001);
    eoc_after(0, 1);
    eoc_after(1, 1);
    eoc_after(2, 1);
    check("t5_frame_end", frame_end, 1);
    @(negedge clk);

    // eoc on the very cycle the watchdog expires wins
    start_frame(32'd1, 32'h100, 32'h200);
    eoc_after(0, 16);
    check("t6_eoc_wins", sif.ver_start, 1);
    check("t6_no_err", timeout_err, 0);
    check("t6_no_frame_end", frame_end, 0);
    eoc_after(1, 2);
    eoc_after(2, 2);
    check("t6_frame_end", frame_end, 1);
    check("t6_err_clear", timeout_err, 0);
    @(negedge clk);

    // Reset during VERTEX aborts without frame_end
    start_frame(32'd2, 32'h1000, 32'h2000);
    eoc_after(0, 2);
    check("t7_ver_start", sif.ver_start, 1);
    @(negedge clk);
    base_fe = n_fe;
    reset = 1'b1;
    #1;
    check("t7_busy_rst", busy, 0);
    check("t7_addr_rst", {sif.curr_addr_vertex, sif.curr_addr_color}, 0);
    check("t7_frame_end_rst", frame_end, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t7_no_frame_end", n_fe - base_fe, 0);
    check("t7_idle", busy, 0);
    start_frame(32'd1, 32'h7000, 32'h8000);
    check("t7_new_fetch", sif.fetch_start, 1);
    check("t7_new_addr", sif.curr_addr_vertex, 32'h7000);
    eoc_after(0, 2);
    eoc_after(1, 2);
    eoc_after(2, 2);
    check("t7_new_frame_end", frame_end, 1);
    @(negedge clk);
    check("t7_new_busy_low", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
